// File: rtl/mc_alu_pkg.sv
// Shared opcode constants and controller state encoding for the mc_alu block.
package mc_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_ADDR = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per step.
// nxt_hi/nxt_lo expose the post-step values so the controller can capture the final step.
module shift_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] m_r;
  logic             div_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   rem_s;
  logic [WIDTH:0]   diff_s;

  // Next partial product or remainder/quotient for one iteration step
  always_comb begin
    sum_s  = {1'b0, acc_r} + (q_r[0] ? {1'b0, m_r} : {(WIDTH+1){1'b0}});
    rem_s  = {acc_r, q_r[WIDTH-1]};
    diff_s = rem_s - {1'b0, m_r};
    last   = (cnt_r == CW'(WIDTH - 1));
    if (div_r) begin
      // a set top bit of the trial difference means the divisor did not fit: restore
      if (diff_s[WIDTH]) begin
        nxt_hi = rem_s[WIDTH-1:0];
        nxt_lo = {q_r[WIDTH-2:0], 1'b0};
      end else begin
        nxt_hi = diff_s[WIDTH-1:0];
        nxt_lo = {q_r[WIDTH-2:0], 1'b1};
      end
    end else begin
      nxt_hi = sum_s[WIDTH:1];
      nxt_lo = {sum_s[0], q_r[WIDTH-1:1]};
    end
  end

  // Operand capture on load, then one shift step per enabled cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= '0;
      q_r   <= '0;
      m_r   <= '0;
      div_r <= 1'b0;
      cnt_r <= '0;
    end else if (load) begin
      acc_r <= '0;
      q_r   <= a;
      m_r   <= b;
      div_r <= is_div;
      cnt_r <= '0;
    end else if (step) begin
      acc_r <= nxt_hi;
      q_r   <= nxt_lo;
      cnt_r <= cnt_r + 1'b1;
    end
  end

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic/add/sub plus iterative MUL/DIV through shift_muldiv.
// All outputs are registered; results hold until the next done pulse.
module mc_alu
  import mc_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             dbz,
  output logic             illegal
);

  state_t           state_r;
  logic             accept_s;
  logic             iter_s;
  logic [WIDTH-1:0] single_res_s;
  logic [WIDTH-1:0] single_hi_s;
  logic             single_dbz_s;
  logic             single_ill_s;
  logic             md_last_s;
  logic [WIDTH-1:0] md_hi_s;
  logic [WIDTH-1:0] md_lo_s;

  // Request acceptance and single-cycle result decode
  always_comb begin
    accept_s     = start && (state_r != RUN);
    iter_s       = (control == OP_MUL) || ((control == OP_DIV) && (b != '0));
    single_res_s = '0;
    single_hi_s  = '0;
    single_dbz_s = 1'b0;
    single_ill_s = 1'b0;
    case (control)
      OP_AND:          single_res_s = a & b;
      OP_OR:           single_res_s = a | b;
      OP_ADD, OP_ADDR: single_res_s = a + b;
      OP_SUB:          single_res_s = a - b;
      OP_MUL:          single_res_s = '0;
      OP_DIV: begin
        // only reached without iteration when the divisor is zero
        single_res_s = '1;
        single_hi_s  = a;
        single_dbz_s = 1'b1;
      end
      default:         single_ill_s = 1'b1;
    endcase
  end

  shift_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .load   (accept_s && iter_s),
    .step   (state_r == RUN),
    .is_div (control == OP_DIV),
    .a      (a),
    .b      (b),
    .last   (md_last_s),
    .nxt_hi (md_hi_s),
    .nxt_lo (md_lo_s)
  );

  // Controller FSM with registered status and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      hi      <= '0;
      dbz     <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (accept_s && iter_s) begin
            state_r <= RUN;
            busy    <= 1'b1;
            dbz     <= 1'b0;
            illegal <= 1'b0;
          end else if (accept_s) begin
            state_r <= DONE;
            done    <= 1'b1;
            result  <= single_res_s;
            hi      <= single_hi_s;
            dbz     <= single_dbz_s;
            illegal <= single_ill_s;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (md_last_s) begin
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            result  <= md_lo_s;
            hi      <= md_hi_s;
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
